// File: rtl/hex_display_scanner_if.sv
// Display-side bundle for hex_display_scanner: captured word, load and blanking
// controls in; active-low anode, segment and decimal-point lines out.
interface hex_display_scanner_if;
  logic [31:0] data_i;
  logic        load_i;
  logic        blank_lz_i;
  logic [7:0]  an_o;
  logic [6:0]  seg_o;
  logic        dp_o;

  modport master (
    output data_i, load_i, blank_lz_i,
    input  an_o, seg_o, dp_o
  );

  modport slave (
    input  data_i, load_i, blank_lz_i,
    output an_o, seg_o, dp_o
  );
endinterface

// File: rtl/hex_display_scanner.sv
// Eight-digit common-anode seven-segment scanner: captures a 32-bit word and
// multiplexes one hex nibble per digit, with optional leading-zero blanking.
module hex_display_scanner #(
  parameter int unsigned CLK_DIV = 100000
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  hex_display_scanner_if.slave  disp
);

  localparam int unsigned      DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_MAX = DIV_W'(CLK_DIV - 1);

  logic [31:0]      data_q;
  logic [DIV_W-1:0] div_q;
  logic [2:0]       dig_q;
  logic [7:0]       an_q;
  logic [6:0]       seg_q;

  logic             tick;
  logic [4:0]       nib_base;
  logic [3:0]       nib;
  logic             blank;
  logic [6:0]       seg_d;

  assign tick     = (div_q == DIV_MAX);
  assign nib_base = {dig_q, 2'b00};
  assign nib      = data_q[nib_base +: 4];

  // A digit is blank only when it and every more-significant nibble are zero.
  assign blank = disp.blank_lz_i && (dig_q != 3'd0) && ((data_q >> nib_base) == '0);

  always_comb begin
    seg_d = '1;
    case (nib)
      4'h0: seg_d = 7'h40;
      4'h1: seg_d = 7'h79;
      4'h2: seg_d = 7'h24;
      4'h3: seg_d = 7'h30;
      4'h4: seg_d = 7'h19;
      4'h5: seg_d = 7'h12;
      4'h6: seg_d = 7'h02;
      4'h7: seg_d = 7'h78;
      4'h8: seg_d = 7'h00;
      4'h9: seg_d = 7'h10;
      4'hA: seg_d = 7'h08;
      4'hB: seg_d = 7'h03;
      4'hC: seg_d = 7'h46;
      4'hD: seg_d = 7'h21;
      4'hE: seg_d = 7'h06;
      4'hF: seg_d = 7'h0E;
      default: seg_d = '1;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      data_q <= '0;
      div_q  <= '0;
      dig_q  <= '0;
      an_q   <= '1;
      seg_q  <= '1;
    end else begin
      if (disp.load_i) begin
        data_q <= disp.data_i;
      end
      div_q <= tick ? '0 : div_q + 1'b1;
      if (tick) begin
        dig_q <= dig_q + 1'b1;
      end
      an_q  <= blank ? '1 : ~(8'b1 << dig_q);
      seg_q <= blank ? '1 : seg_d;
    end
  end

  assign disp.an_o  = an_q;
  assign disp.seg_o = seg_q;
  assign disp.dp_o  = 1'b1;

endmodule

// File: doc/hex_display_scanner.md
# hex_display_scanner

Time-multiplexed driver for an 8-digit common-anode seven-segment display, placed directly downstream of the CPU's `out_o` debug word. It captures a 32-bit value on a load strobe and scans it out one hexadecimal nibble per digit. It produces active-low anode and segment lines, with optional leading-zero blanking. All outputs are registered; the block holds no combinational path from input to pad.

## Interface
- `CLK_DIV`, default 100000: clock cycles each digit stays lit; legal range ≥1.
- `clk_i`  input  1  system clock.
- `rst_ni`  input  1  reset, asynchronous, active-low. One clock; async active-low reset.
- `data_i`  input  32  word to display, typically the CPU `out_o`.
- `load_i`  input  1  capture strobe; samples `data_i` on a rising edge of `clk_i` while high.
- `blank_lz_i`  input  1  enables leading-zero blanking.
- `an_o`  output  8  digit anodes, active-low; bit i drives digit i, where digit 0 is the rightmost and least-significant nibble.
- `seg_o`  output  7  segments, active-low, ordered {g,f,e,d,c,b,a}.
- `dp_o`  output  1  decimal point, active-low; constant 1 (off) in this block.

## Operation
- **Holding register `data_q` (32b)**
  - On a clock edge with `load_i`=1, `data_q` ← `data_i`.
  - Otherwise `data_q` holds.
  - Reset value: 0.
- **Prescaler `div_q`**
  - Width is max(1, $clog2(CLK_DIV)).
  - Counts from 0 to CLK_DIV-1, then wraps to 0.
  - The cycle on which it wraps is the digit tick.
  - With CLK_DIV=1, every cycle is a tick.
- **Digit index `dig_q` (3b)**
  - Increments on each tick and wraps from 7 to 0.
  - Reset value: 0.
- **Nibble select:** digit i displays `nib` = `data_q`[4i+3:4i].
- **Decode (nib → `seg_o`, hex):** 0→40, 1→79, 2→24, 3→30, 4→19, 5→12, 6→02, 7→78, 8→00, 9→10, A→08, b→03, C→46, d→21, E→06, F→0E.
- **Blanking**
  - Digit i is blanked when `blank_lz_i`=1, i≠0, and `data_q`[31:4i]==0.
  - Digit 0 is never blanked, so a zero value shows "0".
  - A blanked digit drives `an_o`=8'hFF and `seg_o`=7'h7F.
- **Output registers**
  - Each clock, `an_o` ← ~(1<<`dig_q`), or 8'hFF if the current digit is blanked.
  - Each clock, `seg_o` ← decode, or 7'h7F if blanked.
  - Exactly one anode is low at a time, or none.
- **Load vs scan:** a load never resets `div_q` or `dig_q`. The scan free-runs regardless of `load_i`.

## Timing
- **Reset**
  - While `rst_ni`=0, outputs are forced immediately, without waiting for a clock edge: `an_o`=8'hFF, `seg_o`=7'h7F, `dp_o`=1.
  - Reset also clears `data_q`, `div_q` and `dig_q` to 0.
  - Reset asserted mid-scan or mid-load has the same effect; the load in progress is lost.
- **First edge after reset release:** `an_o`=8'hFE and `seg_o`=7'h40, i.e. digit 0 showing "0".
- **Output latency:** outputs reflect `dig_q`/`data_q` as of the previous edge, i.e. one cycle latency.
  - Digit change: the tick edge updates `dig_q`; `an_o`/`seg_o` change one edge later.
  - Load: the edge N that sees `load_i`=1 updates `data_q`; the lit digit shows the new nibble at edge N+1.
- **Digit period:** each digit is driven for exactly CLK_DIV cycles. A full frame is 8·CLK_DIV cycles.
- **Continuous load:** with `load_i` held high, the display tracks `data_i` with two edges of latency from input to pad.
- **Blanking changes:** a change of `blank_lz_i` or of leading zeros takes effect at the next output update, i.e. one edge later. It never alters the scan sequence.

## Test plan
All scenarios use CLK_DIV=4.
- **Reset mid-scan:** drive `rst_ni` low between clock edges while digit 5 is lit → `an_o`=FF, `seg_o`=7F, `dp_o`=1 before the next edge. After release, the first edge gives `an_o`=FE and `seg_o`=40.
- **Full frame:** load 0x1234ABCD with `blank_lz_i`=0 → digits 0..7 show `seg_o` = 21, 46, 03, 08, 19, 30, 24, 79.
  - `an_o` sequence: FE, FD, FB, F7, EF, DF, BF, 7F.
  - Each digit is held 4 cycles; the frame repeats after 32 cycles.
- **Leading-zero blanking:** load 0x000000F0 with `blank_lz_i`=1.
  - Digit 0 → `an_o`=FE, `seg_o`=40.
  - Digit 1 → `an_o`=FD, `seg_o`=0E.
  - Digits 2..7 → `an_o`=FF, `seg_o`=7F.
  - With `blank_lz_i`=0, digits 2..7 instead show 40.
- **Zero value:** load 0 with `blank_lz_i`=1 → digit 0 shows `an_o`=FE, `seg_o`=40; all other slots are `an_o`=FF.
- **Load mid-digit:** with digit 3 lit showing A (08), load 0xFFFFFFFF on the 2nd cycle of that digit.
  - `seg_o`=0E one edge after the load edge.
  - `an_o` stays F7 until the normal tick.
  - Scan phase is unchanged: digit 4 starts exactly 4 cycles after digit 3 started.
- **Tracking:** hold `load_i`=1 and increment `data_i` every cycle → `seg_o` for the lit digit follows `data_i` with two-edge latency. No anode glitches: at most one bit of `an_o` is low on every cycle.
